// File: rtl/gf12_sram_banked_1w1r.sv
// 1-write/1-read memory built from NBANKS single-port banks, with write-priority
// bank arbitration, a one-entry deferred-read buffer and a ready/valid read port.

module gf12_sram_sp_model #(
    parameter int DATA_WIDTH = 64,
    parameter int ABITS      = 13
) (
    input  logic                  CLK,
    input  logic                  CE,
    input  logic [ABITS-1:0]      A,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic                  WE,
    input  logic [DATA_WIDTH-1:0] WEM,
    output logic [DATA_WIDTH-1:0] Q
);
    logic [DATA_WIDTH-1:0] mem [2**ABITS];

    // NOTE: storage arrays carry no reset; contents are undefined until written.
    always_ff @(posedge CLK) begin
        if (CE) begin
            if (WE) mem[A] <= (mem[A] & ~WEM) | (D & WEM);
            else    Q      <= mem[A];
        end
    end
endmodule

// Behavioural stand-in for the GF12 8192x64 macro; remove when the macro library is linked.
module GF12_SRAM_SP_8192x64_HD (
    input  logic        CLK,
    input  logic        CE,
    input  logic [12:0] A,
    input  logic [63:0] D,
    input  logic        WE,
    input  logic [63:0] WEM,
    output logic [63:0] Q
);
    gf12_sram_sp_model #(.DATA_WIDTH(64), .ABITS(13)) u_model (
        .CLK(CLK), .CE(CE), .A(A), .D(D), .WE(WE), .WEM(WEM), .Q(Q)
    );
endmodule

module gf12_sram_banked_1w1r #(
    parameter int DATA_WIDTH = 64,
    parameter int BANK_ABITS = 13,
    parameter int NBANKS     = 8,
    parameter int ABITS      = 16,
    parameter int OUT_REG    = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CE0,
    input  logic [ABITS-1:0]      A0,
    input  logic [DATA_WIDTH-1:0] D0,
    input  logic [DATA_WIDTH-1:0] WEM0,
    input  logic                  CE1,
    input  logic [ABITS-1:0]      A1,
    output logic                  RDY1,
    output logic [DATA_WIDTH-1:0] Q1,
    output logic                  QV1,
    output logic [CNT_WIDTH-1:0]  CONFLICTS,
    output logic                  ERR
);
    localparam int BW        = (ABITS > BANK_ABITS) ? ABITS - BANK_ABITS : 1;
    localparam bit USE_MACRO = (DATA_WIDTH == 64) && (BANK_ABITS == 13);

    logic                  pend_q;
    logic [ABITS-1:0]      pend_addr_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  err_q;
    logic                  rd_vld_q;
    logic [BW-1:0]         rd_bank_q;

    logic                  rd_src_v;
    logic [ABITS-1:0]      rd_addr;
    logic [BW-1:0]         wr_bank;
    logic [BW-1:0]         rd_bank;
    logic                  wr_oor;
    logic                  rd_oor;
    logic                  wr_v;
    logic                  conflict;
    logic                  rd_issue;
    logic [DATA_WIDTH-1:0] bank_q [NBANKS];
    logic [DATA_WIDTH-1:0] rdata;

    // The pending read, when present, always takes the read slot ahead of new requests.
    assign RDY1     = !pend_q && !RST;
    assign rd_src_v = !RST && (pend_q || (CE1 && RDY1));
    assign rd_addr  = pend_q ? pend_addr_q : A1;

    if (ABITS > BANK_ABITS) begin : g_bank_idx
        assign wr_bank = A0[ABITS-1:BANK_ABITS];
        assign rd_bank = rd_addr[ABITS-1:BANK_ABITS];
    end else begin : g_single_bank
        assign wr_bank = '0;
        assign rd_bank = '0;
    end

    assign wr_oor   = 32'(wr_bank) >= NBANKS;
    assign rd_oor   = 32'(rd_bank) >= NBANKS;
    assign wr_v     = !RST && CE0 && !wr_oor;
    assign conflict = rd_src_v && wr_v && (rd_bank == wr_bank);
    assign rd_issue = rd_src_v && !conflict;

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_q   <= 1'b0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            rd_vld_q <= 1'b0;
        end else begin
            pend_q   <= conflict;
            rd_vld_q <= rd_issue;
            if (conflict && (cnt_q != '1))
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            if ((CE0 && wr_oor) || (rd_issue && rd_oor))
                err_q <= 1'b1;
        end
    end

    // Datapath-only registers: qualified by pend_q / rd_vld_q, so they need no reset.
    always_ff @(posedge CLK) begin
        if (conflict) pend_addr_q <= rd_addr;
        rd_bank_q <= rd_bank;
    end

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        logic                  ce;
        logic                  we;
        logic [BANK_ABITS-1:0] row;

        assign we  = wr_v && (32'(wr_bank) == b);
        assign ce  = we || (rd_issue && (32'(rd_bank) == b));
        assign row = we ? A0[BANK_ABITS-1:0] : rd_addr[BANK_ABITS-1:0];

        if (USE_MACRO) begin : g_macro
            GF12_SRAM_SP_8192x64_HD u_sram (
                .CLK(CLK), .CE(ce), .A(row), .D(D0), .WE(we), .WEM(WEM0), .Q(bank_q[b])
            );
        end else begin : g_model
            gf12_sram_sp_model #(.DATA_WIDTH(DATA_WIDTH), .ABITS(BANK_ABITS)) u_sram (
                .CLK(CLK), .CE(ce), .A(row), .D(D0), .WE(we), .WEM(WEM0), .Q(bank_q[b])
            );
        end
    end

    // NOTE: rdata gets a default before the loop so no path leaves it unassigned (no latch).
    // An out-of-range bank index matches no bank and returns zero.
    always_comb begin
        rdata = '0;
        for (int b = 0; b < NBANKS; b++)
            if (32'(rd_bank_q) == b) rdata = bank_q[b];
    end

    if (OUT_REG != 0) begin : g_oreg
        logic                  qv_q;
        logic [DATA_WIDTH-1:0] q_q;

        always_ff @(posedge CLK) begin
            if (RST) begin
                qv_q <= 1'b0;
                q_q  <= '0;
            end else begin
                qv_q <= rd_vld_q;
                q_q  <= rdata;
            end
        end

        assign QV1 = qv_q && !RST;
        assign Q1  = RST ? '0 : q_q;
    end else begin : g_no_oreg
        assign QV1 = rd_vld_q && !RST;
        assign Q1  = rdata;
    end

    assign CONFLICTS = RST ? '0 : cnt_q;
    assign ERR       = err_q && !RST;
endmodule
